// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - instruction-fetch front end with prefetch queue and redirect flush
//
// Purpose: drives the fetch PC onto the instruction-memory port and captures the
// same-cycle instruction into a DEPTH-entry queue. The queue is handed to decode over
// a valid/ready handshake. A redirect loads a new fetch PC and flushes the queue.
//
// Optional feature: define IFU_ADDR_CHECK_EN to range/alignment-check every fetch address.
// A failing address halts fetch and raises the sticky fetch_err flag.
//
// Ports:
//   clk            in   clock, all state updates on the rising edge
//   reset          in   synchronous active-low reset
//   i_inst_addr    out  byte address presented to instruction memory (always fetch_pc)
//   i_inst_rdata   in   instruction for i_inst_addr, same cycle
//   redirect_valid in   load redirect_pc as the new fetch PC and flush the queue
//   redirect_pc    in   redirect target byte address
//   out_valid      out  head entry available to decode
//   out_ready      in   decode accepts the head entry
//   out_instr      out  head instruction (0 when out_valid is low)
//   out_pc         out  head instruction byte address (0 when out_valid is low)
//   fetch_err      out  sticky bad-fetch-address flag (0 unless IFU_ADDR_CHECK_EN)

module ifu_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fetch_err
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || IM_WORDS < 1) begin : g_param_check
    $error("ifu_prefetch: DEPTH must be a power of two >= 2 and IM_WORDS >= 1");
  end

  typedef enum logic {RUN, HALT} state_t;

  state_t        state, state_next;
  logic [31:0]   fetch_pc;
  logic [AW-1:0] head, tail;
  logic [AW:0]   count;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic pop, push, push_slot, fetch_ok, redirect_ok, fetch_fail;

`ifdef IFU_ADDR_CHECK_EN
  localparam logic [32:0] ADDR_LIMIT = {1'b0, RESET_PC} + 33'(IM_WORDS) * 33'd4;

  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= RESET_PC) && ({1'b0, a} < ADDR_LIMIT);
  endfunction

  assign fetch_ok    = addr_ok(fetch_pc);
  assign redirect_ok = addr_ok(redirect_pc);
`else
  assign fetch_ok    = 1'b1;
  assign redirect_ok = 1'b1;
`endif

  assign i_inst_addr = fetch_pc;
  assign out_valid   = (count != '0);
  assign out_pc      = out_valid ? pc_mem[head]    : 32'd0;
  assign out_instr   = out_valid ? instr_mem[head] : 32'd0;

  assign pop = out_valid & out_ready;

  // A free slot (or one freed by this cycle's pop) is needed; redirect suppresses the push.
  assign push_slot  = (state == RUN) & ((count < (AW+1)'(DEPTH)) | pop) & ~redirect_valid;
  assign push       = push_slot & fetch_ok;
  assign fetch_fail = push_slot & ~fetch_ok;

  // Fetch state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (redirect_valid) begin
      state_next = redirect_ok ? RUN : HALT;
    end else if (fetch_fail) begin
      state_next = HALT;
    end
  end

`ifdef IFU_ADDR_CHECK_EN
  logic err_q, err_next;

  always_comb begin
    err_next = err_q;
    if (redirect_valid) begin
      err_next = ~redirect_ok;
    end else if (fetch_fail) begin
      err_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_next;
    end
  end

  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

  // Pointers, occupancy and fetch PC. A redirect flushes everything, including an entry
  // handed to decode in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        tail     <= tail + AW'(1);
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) begin
        head <= head + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage needs no reset; out_valid gates what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]    <= fetch_pc;
      instr_mem[tail] <= i_inst_rdata;
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb/tb_ifu_prefetch.sv - scoreboard testbench for ifu_prefetch
module tb_ifu_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int          IM_WORDS = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_inst_addr;
  logic [31:0] i_inst_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fetch_err;

  always #5 clk = ~clk;

  assign i_inst_rdata = i_inst_addr ^ 32'hA5A5_0000;

  ifu_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .IM_WORDS(IM_WORDS)) dut (
    .clk(clk), .reset(reset),
    .i_inst_addr(i_inst_addr), .i_inst_rdata(i_inst_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .fetch_err(fetch_err)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        model_q[$];
  ent_t        sb_q[$];
  logic [31:0] mpc;
  bit          m_halt;
  bit          m_err;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
`ifdef IFU_ADDR_CHECK_EN
    longint la;
    la = longint'(a);
    return (a[1:0] == 2'b00) && (la >= longint'(RESET_PC)) &&
           (la < longint'(RESET_PC) + 4 * longint'(IM_WORDS));
`else
    return (a == a);
`endif
  endfunction

  // Reference model: a plain queue of fetched words, applied once per clock edge.
  task automatic model_step(input bit reset_v, input bit rv, input logic [31:0] rpc, input bit rdy);
    bit   do_pop;
    ent_t e;
    if (!reset_v) begin
      model_q.delete(); sb_q.delete();
      mpc = RESET_PC; m_halt = 0; m_err = 0;
    end else if (rv) begin
      model_q.delete(); sb_q.delete();
      mpc = rpc; m_halt = !addr_ok(rpc); m_err = m_halt;
    end else begin
      do_pop = (model_q.size() > 0) && rdy;
      if (!m_halt && (model_q.size() < DEPTH || do_pop)) begin
        if (addr_ok(mpc)) begin
          e.pc = mpc;
          e.instr = mpc ^ 32'hA5A5_0000;
          model_q.push_back(e);
          sb_q.push_back(e);
          mpc = mpc + 32'd4;
        end else begin
          m_halt = 1; m_err = 1;
        end
      end
      if (do_pop) void'(model_q.pop_front());
    end
  endtask

  task automatic cyc(input bit reset_v, input bit rv, input logic [31:0] rpc, input bit rdy);
    reset = reset_v; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    @(posedge clk); #1;
    model_step(reset_v, rv, rpc, rdy);
    chk("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
    chk("i_inst_addr", i_inst_addr, mpc);
    chk("fetch_err", 32'(fetch_err), 32'(m_err));
    if (model_q.size() == 0) begin
      chk("idle_out_pc", out_pc, 32'd0);
      chk("idle_out_instr", out_instr, 32'd0);
    end
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 32'd0, rdy);
  endtask

  // Monitor: every handshake must deliver the oldest outstanding expected entry.
  always @(negedge clk) begin
    ent_t e;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got pc %h with no expected entry at %0t", out_pc, $time);
      end else begin
        e = sb_q.pop_front();
        chk("out_pc", out_pc, e.pc);
        chk("out_instr", out_instr, e.instr);
      end
    end
  end

  initial begin
    logic [31:0] rpc;
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; out_ready = 1'b0;

    cyc(1'b0, 1'b0, 32'd0, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b0);
    chk("reset_addr", i_inst_addr, 32'h0000_3000);
    chk("reset_valid", 32'(out_valid), 32'd0);

    // Streaming with decode always ready.
    run(6, 1'b1);

    // Backpressure fills the queue, then drains in order.
    cyc(1'b0, 1'b0, 32'd0, 1'b0);
    run(8, 1'b0);
    chk("full_addr_hold", i_inst_addr, 32'h0000_3010);
    run(6, 1'b1);

    // Full queue, pop and redirect together.
    run(5, 1'b0);
    cyc(1'b1, 1'b1, 32'h0000_4000, 1'b1);
    chk("redirect_flush_valid", 32'(out_valid), 32'd0);
    cyc(1'b1, 1'b0, 32'd0, 1'b1);
    chk("redirect_first_pc", out_pc, 32'h0000_4000);
    run(2, 1'b1);

    // Reset with three entries queued.
    cyc(1'b0, 1'b0, 32'd0, 1'b0);
    run(3, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b0);
    chk("midreset_addr", i_inst_addr, 32'h0000_3000);
    run(4, 1'b1);

`ifdef IFU_ADDR_CHECK_EN
    cyc(1'b1, 1'b1, 32'h0000_6FFC, 1'b1);
    run(4, 1'b1);
    chk("halt_err", 32'(fetch_err), 32'd1);
    cyc(1'b1, 1'b1, 32'h0000_3002, 1'b1);
    run(3, 1'b1);
    chk("bad_redirect_err", 32'(fetch_err), 32'd1);
    cyc(1'b1, 1'b1, 32'h0000_3000, 1'b1);
    run(4, 1'b1);
    chk("resume_err", 32'(fetch_err), 32'd0);
`else
    cyc(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    run(4, 1'b1);
    chk("wrap_err", 32'(fetch_err), 32'd0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      case ($urandom % 4)
        0, 1:    rpc = RESET_PC + 32'(4 * $urandom_range(0, IM_WORDS - 1));
        2:       rpc = RESET_PC + 32'(4 * IM_WORDS) - 32'(4 * $urandom_range(1, 3));
        default: rpc = $urandom;
      endcase
      cyc(($urandom % 60) != 0, ($urandom % 12) == 0, rpc, ($urandom % 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
